// File: rtl/riscv_mc_ctrl_if.sv
// Control-side bundle for the multi-cycle RV32 controller: decoded op and
// datapath/memory status in, every strobe and select out.
//
// Handshake semantics (imem and dmem alike): the controller raises *_req and
// holds it, with dmem_we stable, until the cycle in which the matching
// *_ready is sampled high. That cycle completes the transfer. *_ready is
// only meaningful while *_req is high.
interface riscv_mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       op;
  logic             alu_zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic             alu_src_b;
  logic             alu_op;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic             halted;
  logic [1:0]       trap_cause;
  logic [2:0]       dbg_state;

  modport master (
    input  op, alu_zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
           alu_src_b, alu_op, retire, retired_cnt, halted, trap_cause, dbg_state
  );

  modport slave (
    output op, alu_zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
           alu_src_b, alu_op, retire, retired_cnt, halted, trap_cause, dbg_state
  );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle control FSM for the RV32 subset core. Sequences
// FETCH/DECODE/EXEC/MEM/WB, traps on illegal ops and memory timeouts, and
// counts retired instructions.
// Op encoding: 0 NOP, 1 UNKNOWN, 2 ADDI, 3 LUI, 4 SB, 5 LBU, 6 BEQ, 7 BNE,
// 8 JAL, 9 JALR; anything above 9 is illegal.
module riscv_mc_ctrl #(
  parameter int CNT_W     = 32,
  parameter int TIMEOUT_P = 64
) (
  input  logic            clk,
  input  logic            rst,
  riscv_mc_ctrl_if.master bus
);
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_UNK  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LUI  = 4'd3;
  localparam logic [3:0] OP_SB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_BNE  = 4'd7;
  localparam logic [3:0] OP_JAL  = 4'd8;
  localparam logic [3:0] OP_JALR = 4'd9;

  localparam int WAIT_W = (TIMEOUT_P > 0) ? $clog2(TIMEOUT_P + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_P);
  localparam bit TIMEOUT_EN = (TIMEOUT_P > 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
  logic       alu_src_b, alu_op, retire;
  logic [1:0] pc_sel, wb_sel;

  // State, wait counter, trap cause and retire counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and strobe decode. wait_d defaults to 0 so any entry into
  // FETCH or MEM starts a fresh wait count; it only grows while a request
  // is stalled. Ready in the limit cycle takes priority over the trap.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    alu_src_b = 1'b0;
    alu_op    = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (TIMEOUT_EN && (wait_q == WAIT_MAX)) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else if (TIMEOUT_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (bus.op == OP_NOP) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if ((bus.op == OP_UNK) || (bus.op > OP_JALR)) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (bus.op)
          OP_ADDI, OP_LUI, OP_JALR: begin
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_SB, OP_LBU: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_op  = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
            pc_sel  = ((bus.op == OP_BEQ) == bus.alu_zero) ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end
          OP_JAL: state_d = S_WB;
          default: begin
            // op changed to something non-executable after DECODE
            state_d = S_TRAP;
            cause_d = 2'd1;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (bus.op == OP_SB);
        if (bus.dmem_ready) begin
          if (bus.op == OP_SB) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (TIMEOUT_EN && (wait_q == WAIT_MAX)) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else if (TIMEOUT_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        case (bus.op)
          OP_LBU:  wb_sel = 2'd1;
          OP_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
          OP_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
          default: wb_sel = 2'd0;
        endcase
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Retire counter; wraps naturally at all-ones.
  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // Outputs are forced low while rst is high so an in-flight request drops
  // immediately rather than at the next clock.
  assign bus.imem_req    = imem_req  & ~rst;
  assign bus.dmem_req    = dmem_req  & ~rst;
  assign bus.dmem_we     = dmem_we   & ~rst;
  assign bus.ir_we       = ir_we     & ~rst;
  assign bus.pc_we       = pc_we     & ~rst;
  assign bus.pc_sel      = pc_sel    & {2{~rst}};
  assign bus.rf_we       = rf_we     & ~rst;
  assign bus.wb_sel      = wb_sel    & {2{~rst}};
  assign bus.alu_src_b   = alu_src_b & ~rst;
  assign bus.alu_op      = alu_op    & ~rst;
  assign bus.retire      = retire    & ~rst;
  assign bus.retired_cnt = cnt_q;
  assign bus.halted      = (state_q == S_TRAP);
  assign bus.trap_cause  = cause_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: directed test-plan cases plus
// randomized legal instructions with random memory wait times, checked
// against per-instruction latency/select rules.
module tb_riscv_mc_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  riscv_mc_ctrl_if #(.CNT_W(32)) bus();

  riscv_mc_ctrl #(.CNT_W(32), .TIMEOUT_P(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d @%0t", tag, obs, exp, $time);
  endtask

  // reference rules, expressed per opcode
  function automatic int base_lat(input logic [3:0] o);
    case (o)
      4'd0:       return 2;
      4'd6, 4'd7: return 3;
      4'd5:       return 5;
      default:    return 4;
    endcase
  endfunction
  function automatic bit is_mem(input logic [3:0] o);
    return (o == 4'd4) || (o == 4'd5);
  endfunction
  function automatic logic [1:0] exp_pc_sel(input logic [3:0] o, input logic z);
    if (o == 4'd6) return z ? 2'd1 : 2'd0;
    if (o == 4'd7) return z ? 2'd0 : 2'd1;
    if (o == 4'd8) return 2'd1;
    if (o == 4'd9) return 2'd2;
    return 2'd0;
  endfunction
  function automatic logic exp_rf_we(input logic [3:0] o);
    return (o == 4'd2) || (o == 4'd3) || (o == 4'd5) || (o == 4'd8) || (o == 4'd9);
  endfunction
  function automatic logic [1:0] exp_wb_sel(input logic [3:0] o);
    if (o == 4'd5) return 2'd1;
    if ((o == 4'd8) || (o == 4'd9)) return 2'd2;
    return 2'd0;
  endfunction

  // Apply reset; checks outputs while held and the post-reset state.
  // Returns at a negedge inside the first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    check("rst_retire", bus.retire, 0);
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("post_rst_imem_req", bus.imem_req, 1);
    check("post_rst_halted", bus.halted, 0);
    check("post_rst_cause", bus.trap_cause, 0);
    check("post_rst_cnt", bus.retired_cnt, 0);
    exp_cnt = 0;
    @(negedge clk);
  endtask

  // Driver: one instruction, di/dm = wait cycles before imem/dmem ready.
  task automatic run_instr(input logic [3:0] op_i, input int di, input int dm, input logic z);
    int cyc, ireq, dreq, dwe_bad;
    bit done, fetched;
    logic [1:0] r_pc_sel, r_wb_sel;
    logic r_rf, r_pcwe, r_aluop, r_ret;
    cyc = 0; ireq = 0; dreq = 0; dwe_bad = 0; done = 0; fetched = 0;
    r_pc_sel = 0; r_wb_sel = 0; r_rf = 0; r_pcwe = 0; r_aluop = 0; r_ret = 0;
    exp_q.push_back(base_lat(op_i) + di + (is_mem(op_i) ? dm : 0));
    check("retired_cnt", bus.retired_cnt, exp_cnt);
    bus.alu_zero = z;
    while (!done && cyc < 40) begin
      bus.op = fetched ? op_i : 4'($urandom_range(0, 15));
      #1;
      bus.imem_ready = bus.imem_req && (ireq == di);
      bus.dmem_ready = bus.dmem_req && (dreq == dm);
      #1;
      cyc++;
      if (bus.imem_req) ireq++;
      if (bus.dmem_req) begin
        dreq++;
        if (bus.dmem_we !== (op_i == 4'd4)) dwe_bad++;
      end
      if (bus.ir_we) fetched = 1;
      if (bus.retire || bus.halted) begin
        done = 1;
        r_ret = bus.retire; r_pcwe = bus.pc_we; r_pc_sel = bus.pc_sel;
        r_rf = bus.rf_we; r_wb_sel = bus.wb_sel; r_aluop = bus.alu_op;
      end
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    check("retire_seen", r_ret, 1);
    check("latency", cyc, exp_q.pop_front());
    check("imem_req_cycles", ireq, di + 1);
    check("dmem_req_cycles", dreq, is_mem(op_i) ? dm + 1 : 0);
    check("dmem_we", dwe_bad, 0);
    check("pc_we", r_pcwe, 1);
    check("pc_sel", r_pc_sel, exp_pc_sel(op_i, z));
    check("rf_we", r_rf, exp_rf_we(op_i));
    check("wb_sel", r_wb_sel, exp_wb_sel(op_i));
    check("alu_op", r_aluop, (op_i == 4'd6) || (op_i == 4'd7));
    exp_cnt = exp_cnt + 1;
  endtask

  // Fetch with ready at once, present op in DECODE.
  task automatic fetch_decode(input logic [3:0] op_i);
    bus.op = 4'($urandom_range(0, 15));
    bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    bus.op = op_i;
    @(negedge clk);
  endtask

  task automatic illegal_op(input logic [3:0] op_i);
    fetch_decode(op_i);
    #1;
    check("trap_halted", bus.halted, 1);
    check("trap_cause_illegal", bus.trap_cause, 1);
    repeat (3) @(negedge clk);
    #1;
    check("trap_no_imem_req", bus.imem_req, 0);
    check("trap_still_halted", bus.halted, 1);
    do_reset();
  endtask

  initial begin
    int cnt;
    logic [3:0] legal[10];
    legal = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2};
    bus.op = 0; bus.alu_zero = 0; bus.imem_ready = 0; bus.dmem_ready = 0;
    do_reset();

    // directed test-plan cases
    run_instr(4'd2, 0, 0, 1'b0);   // ADDI
    run_instr(4'd6, 0, 0, 1'b1);   // BEQ taken
    run_instr(4'd7, 0, 0, 1'b1);   // BNE not taken
    run_instr(4'd5, 0, 3, 1'b0);   // LBU, dmem 3 waits -> 8 cycles
    run_instr(4'd9, 0, 0, 1'b0);   // JALR
    run_instr(4'd8, 0, 0, 1'b0);   // JAL
    run_instr(4'd4, 4, 4, 1'b0);   // SB, ready exactly at the limit
    run_instr(4'd0, 2, 0, 1'b0);   // NOP
    check("cnt_after_directed", bus.retired_cnt, exp_cnt);

    // random legal instructions
    for (int i = 0; i < 40; i++)
      run_instr(legal[$urandom_range(0, 9)], $urandom_range(0, TO),
                $urandom_range(0, TO), 1'($urandom_range(0, 1)));
    check("cnt_after_random", bus.retired_cnt, exp_cnt);

    // illegal ops
    illegal_op(4'd1);
    illegal_op(4'd12);

    // imem timeout: TO+1 request cycles (count 0..TO), then TRAP
    cnt = 0;
    bus.imem_ready = 1'b0;
    while (!bus.halted && cnt < 20) begin
      #1;
      if (bus.imem_req) cnt++;
      @(negedge clk);
    end
    #1;
    check("imem_to_cycles", cnt, TO + 1);
    check("imem_to_cause", bus.trap_cause, 2);
    check("imem_to_halted", bus.halted, 1);
    do_reset();

    // dmem timeout on SB
    fetch_decode(4'd4);            // DECODE
    @(negedge clk);                // EXEC -> MEM
    cnt = 0;
    while (!bus.halted && cnt < 20) begin
      #1;
      if (bus.dmem_req) cnt++;
      @(negedge clk);
    end
    #1;
    check("dmem_to_cycles", cnt, TO + 1);
    check("dmem_to_cause", bus.trap_cause, 3);
    check("dmem_to_retire", bus.retire, 0);
    do_reset();

    // reset mid-MEM on SB
    run_instr(4'd3, 0, 0, 1'b0);   // LUI so the counter is non-zero
    fetch_decode(4'd4);
    @(negedge clk);
    @(negedge clk);                // second MEM cycle
    #1;
    check("mid_mem_req", bus.dmem_req, 1);
    rst = 1'b1;
    #1;
    check("mid_mem_req_drop", bus.dmem_req, 0);
    check("mid_mem_no_retire", bus.retire, 0);
    check("mid_mem_cnt_clear", bus.retired_cnt, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_mem_refetch", bus.imem_req, 1);
    @(negedge clk);
    exp_cnt = 0;
    run_instr(4'd2, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
- Multi-cycle control FSM for the single-issue RV32 subset core (NOP, ADDI, LUI, SB, LBU, BEQ, BNE, JAL, JALR).
- Consumes the decoded t_risc_v_op plus ALU and memory status.
- Drives every datapath enable and mux select, and sequences the instruction/data memory handshakes.
- Traps on illegal opcodes and on memory timeouts; counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT_P, 64, max wait cycles for imem/dmem ready; 0 disables timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- op  in  4  decoded t_risc_v_op of current IR; valid from DECODE onward
- alu_zero  in  1  ALU result == 0
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (SB) when 1, read (LBU) when 0
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0=PC+4, 1=PC+imm (branch/JAL), 2=ALU result (JALR)
- rf_we  out  1  register file write
- wb_sel  out  2  0=ALU, 1=load byte, 2=PC+4
- alu_src_b  out  1  0=rs2, 1=immediate
- alu_op  out  1  t_alu: 0=ADD, 1=SUB
- retire  out  1  one-cycle pulse per completed instruction
- retired_cnt  out  CNT_W  retired-instruction count, wraps
- halted  out  1  sticky; FSM in TRAP
- trap_cause  out  2  0=none, 1=illegal op, 2=imem timeout, 3=dmem timeout

Behaviour:
- Reset (async): state=FETCH, retired_cnt=0, trap_cause=0, wait counter=0. All strobes and selects are 0 while rst is high. An in-flight request drops immediately.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Strobes are Moore except where gated by a ready input, as stated below.
- Defaults are 0 in every state unless listed.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_we=1 in the same cycle, then -> DECODE.
- DECODE: register read. Transitions by op:
  - NOP: pc_we=1, pc_sel=0, retire=1 -> FETCH.
  - UNKNOWN or encoding >9: -> TRAP, cause=1.
  - Otherwise -> EXEC.
- EXEC:
  - ADDI, LUI, SB, LBU, JALR: alu_src_b=1, alu_op=ADD. SB/LBU -> MEM; others -> WB.
  - BEQ/BNE: alu_src_b=0, alu_op=SUB, pc_we=1, retire=1.
    - Taken = alu_zero for BEQ, !alu_zero for BNE.
    - pc_sel=1 if taken, else 0. -> FETCH.
  - JAL: -> WB.
- MEM:
  - dmem_req=1; dmem_we=1 for SB, 0 for LBU.
  - Address and write data hold from EXEC; the datapath registers the ALU output.
  - On dmem_ready:
    - SB: pc_we=1, pc_sel=0, retire=1 -> FETCH.
    - LBU: -> WB.
- WB: rf_we=1, pc_we=1, retire=1 -> FETCH. Selects by op:
  - ADDI/LUI: wb_sel=0, pc_sel=0.
  - LBU: wb_sel=1, pc_sel=0.
  - JAL: wb_sel=2, pc_sel=1.
  - JALR: wb_sel=2, pc_sel=2. The datapath clears bit 0.
- Latency with ready on first request cycle:
  - NOP 2 cycles; BEQ/BNE 3.
  - ADDI/LUI/JAL/JALR 4; SB 4; LBU 5.
  - Each extra ready-wait cycle adds 1.
- Timeout: the wait counter clears on entry to FETCH/MEM and increments each cycle the request is held without ready. If TIMEOUT_P>0 and the count reaches TIMEOUT_P with ready still low -> TRAP, cause=2 (FETCH) or 3 (MEM). Ready arriving in the same cycle the limit is reached wins (no trap).
- TRAP: halted=1, all strobes 0, trap_cause held. Exit only via rst.
- retired_cnt increments on each retire pulse and wraps from all-ones to 0.
- The op input is sampled only in DECODE/EXEC/MEM/WB. Changes to op during FETCH are ignored.

Test Plan:
- Reset then ADDI with imem_ready and dmem_ready tied high -> FETCH, DECODE, EXEC, WB. rf_we=1 and pc_we=1 in cycle 4, wb_sel=0, retire=1, retired_cnt=1.
- BEQ with alu_zero=1, then BNE with alu_zero=1 -> first gives pc_sel=1; second gives pc_sel=0. pc_we=1 in EXEC both times, alu_op=SUB, retired_cnt=2.
- LBU with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles, then WB with wb_sel=1, rf_we=1. Total 8 cycles.
- JALR -> WB asserts rf_we=1, wb_sel=2, pc_sel=2. JAL asserts pc_sel=1.
- op=UNKNOWN (1), and separately op=12 -> TRAP after DECODE: halted=1, trap_cause=1, no further imem_req. Assert rst -> FETCH, cause 0.
- TIMEOUT_P=4 with imem_ready held low -> TRAP with trap_cause=2 after 4 wait cycles. Ready arriving at wait 4 -> no trap. Assert rst mid-MEM on SB -> dmem_req drops the same cycle, no retire.
